// File: rtl/tdc_ctrl_pkg.sv
// rtl/tdc_ctrl_pkg.sv - shared state encoding and width helpers for the TDC sequencer
package tdc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_CAPT   = 3'd4,
        ST_ACCUM  = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    localparam int NSAMP_MAX_LOG2 = 3;

    function automatic int code_width(input int tap_w);
        return $clog2(tap_w + 1);
    endfunction

    function automatic int acc_width(input int code_w);
        return code_w + NSAMP_MAX_LOG2;
    endfunction

endpackage

// File: rtl/tdc_therm_decoder.sv
// rtl/tdc_therm_decoder.sv - thermometer popcount with monotonicity (bubble) check
module tdc_therm_decoder #(
    parameter int TAP_W  = 32,
    parameter int CODE_W = 6
) (
    input  logic [TAP_W-1:0]  taps,
    output logic [CODE_W-1:0] code,
    output logic              bubble
);

    always_comb begin
        code = '0;
        for (int i = 0; i < TAP_W; i++) begin
            code = code + CODE_W'(taps[i]);
        end
    end

    // A clean thermometer code is a run of ones from the LSB, so adding one leaves no overlap.
    assign bubble = |(taps & (taps + TAP_W'(1)));

endmodule

// File: rtl/tdc_meas_sequencer.sv
// rtl/tdc_meas_sequencer.sv - clear/launch/capture sequencer with 1..8 sample averaging
module tdc_meas_sequencer
    import tdc_ctrl_pkg::*;
#(
    parameter int TAP_W  = 32,
    parameter int CODE_W = code_width(TAP_W),
    parameter int ACC_W  = acc_width(CODE_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [3:0]       delay_cfg,
    input  logic [1:0]       nsamp_log2,
    output logic             tdc_clear,
    output logic             tdc_launch,
    output logic             tdc_capture,
    input  logic [TAP_W-1:0] tdc_taps,
    output logic [7:0]       res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic             bubble_err
);

    state_t              state, state_nxt;
    logic [3:0]          delay_q;
    logic [1:0]          nsamp_q;
    logic [3:0]          wait_cnt;
    logic [3:0]          samp_cnt;
    logic [3:0]          samp_nxt;
    logic                samp_last;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    avg;
    logic [TAP_W-1:0]    taps_q;
    logic                bubble_q;
    logic [CODE_W-1:0]   code;
    logic                bubble;

    tdc_therm_decoder #(
        .TAP_W  (TAP_W),
        .CODE_W (CODE_W)
    ) u_decoder (
        .taps   (taps_q),
        .code   (code),
        .bubble (bubble)
    );

    assign samp_nxt   = samp_cnt + 4'd1;
    assign samp_last  = (samp_nxt == (4'd1 << nsamp_q));
    assign avg        = acc >> nsamp_q;
    assign busy       = (state != ST_IDLE);
    assign bubble_err = bubble_q;

    always_comb begin
        state_nxt   = state;
        tdc_clear   = 1'b0;
        tdc_launch  = 1'b0;
        tdc_capture = 1'b0;
        res_valid   = 1'b0;
        res_data    = 8'd0;
        case (state)
            ST_IDLE:   if (start && ena) state_nxt = ST_CLEAR;
            ST_CLEAR: begin
                tdc_clear = 1'b1;
                state_nxt = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                tdc_launch = 1'b1;
                state_nxt  = ST_WAIT;
            end
            ST_WAIT:   if (wait_cnt == 4'd0) state_nxt = ST_CAPT;
            ST_CAPT: begin
                tdc_capture = 1'b1;
                state_nxt   = ST_ACCUM;
            end
            ST_ACCUM:  state_nxt = samp_last ? ST_DONE : ST_CLEAR;
            ST_DONE: begin
                res_valid = 1'b1;
                res_data  = 8'(avg);
                if (res_ready) state_nxt = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
        // Losing the tile enable abandons the measurement from any active state.
        if (!ena && state != ST_IDLE) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            delay_q  <= '0;
            nsamp_q  <= '0;
            wait_cnt <= '0;
            samp_cnt <= '0;
            acc      <= '0;
            taps_q   <= '0;
            bubble_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ena) begin
                case (state)
                    ST_IDLE: if (start) begin
                        delay_q  <= delay_cfg;
                        nsamp_q  <= nsamp_log2;
                        acc      <= '0;
                        samp_cnt <= '0;
                        bubble_q <= 1'b0;
                    end
                    ST_LAUNCH: wait_cnt <= delay_q;
                    ST_WAIT:   if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                    ST_CAPT:   taps_q <= tdc_taps;
                    ST_ACCUM: begin
                        acc      <= acc + ACC_W'(code);
                        samp_cnt <= samp_nxt;
                        if (bubble) bubble_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
